// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX operand forwarding, load-use and redirect
// stall/flush generation, a multi-cycle execute FSM and a stall-cycle counter.
module hazard_unit #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MultiCycleE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             StallE,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             McBusy,
    output logic [CNT_W-1:0] StallCount
);

    localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lwStall;
    logic          mcStall;

    // Operand forwarding: the younger producer in MEM wins over WB.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
    end

    // Hazard detection; the multi-cycle stall is masked during reset so an
    // aborted op never leaks a stall into the reset cycle.
    always_comb begin
        lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                  ((Rs1D == RdE) || (Rs2D == RdE));
        mcStall = !reset && (((state == IDLE) && MultiCycleE) ||
                             ((state == BUSY) && (cnt != '0)));
        StallF  = lwStall | mcStall;
        StallD  = lwStall | mcStall;
        StallE  = mcStall;
        FlushM  = mcStall;
        FlushE  = !mcStall && (lwStall || PCSrcE);
        FlushD  = !mcStall && PCSrcE;
        McBusy  = !reset && (state == BUSY);
    end

    // Multi-cycle FSM: entry cycle plus MC_LAT-2 busy stalls, then one release
    // cycle in which the op advances. Stall counter saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            StallCount <= '0;
        end else begin
            case (state)
                IDLE: if (MultiCycleE) begin
                    state <= BUSY;
                    cnt   <= CW'(MC_LAT - 2);
                end
                BUSY: if (cnt != '0) cnt <= cnt - CW'(1);
                      else           state <= IDLE;
                default: state <= IDLE;
            endcase
            if (StallF && (StallCount != '1))
                StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench: two instances (MC_LAT=4 wide counter, MC_LAT=2 with a
// 3-bit counter to reach saturation) share the same stimulus.
module tb_hazard_unit;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteM, RegWriteW, PCSrcE, MultiCycleE;
    logic [1:0] ResultSrcE;

    logic sf4, sd4, fd4, se4, fe4, fm4, mb4;
    logic sf2, sd2, fd2, se2, fe2, fm2, mb2;
    logic [1:0] fa4, fb4, fa2, fb2;
    logic [31:0] cnt4;
    logic [2:0]  cnt2;

    always #5 clk = ~clk;

    hazard_unit #(.MC_LAT(4), .CNT_W(32)) u_dut4 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E),
        .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MultiCycleE(MultiCycleE), .StallF(sf4), .StallD(sd4), .FlushD(fd4),
        .StallE(se4), .FlushE(fe4), .FlushM(fm4), .ForwardAE(fa4),
        .ForwardBE(fb4), .McBusy(mb4), .StallCount(cnt4));

    hazard_unit #(.MC_LAT(2), .CNT_W(3)) u_dut2 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E),
        .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MultiCycleE(MultiCycleE), .StallF(sf2), .StallD(sd2), .FlushD(fd2),
        .StallE(se2), .FlushE(fe2), .FlushM(fm2), .ForwardAE(fa2),
        .ForwardBE(fb2), .McBusy(mb2), .StallCount(cnt2));

    typedef struct {
        logic [1:0]  fa, fb;
        logic [6:0]  ctl4, ctl2;   // {StallF,StallD,FlushD,StallE,FlushE,FlushM,McBusy}
        logic [31:0] c4;
        logic [2:0]  c2;
        bit          cv;
        bit          mc4, mc2, lw;
    } exp_t;

    exp_t q[$];

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    int   left4 = 0, left2 = 0;
    bit   rel4 = 0, rel2 = 0;
    logic [31:0] m_c4 = '0;
    logic [2:0]  m_c2 = '0;
    bit   m_cv = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [6:0] ctl(input bit mc, input bit busy, input bit lw, input bit pc);
        bit s;
        s = lw | mc;
        return {s, s, !mc & pc, mc, !mc & (lw | pc), mc, busy};
    endfunction

    // Expected (mcStall, McBusy) for a model instance given its state.
    function automatic bit [1:0] mcexp(input int left, input bit rel);
        if (reset)       return 2'b00;
        if (rel)         return 2'b01;
        if (left > 0)    return 2'b11;
        return {MultiCycleE, 1'b0};
    endfunction

    task automatic adv(input int lat, input bit mce, input bit rst,
                       inout int left, inout bit rel);
        if (rst)           begin left = 0; rel = 0; end
        else if (rel)      rel = 0;
        else if (left > 0) begin left--; if (left == 0) rel = 1; end
        else if (mce)      begin left = lat - 2; rel = (lat == 2); end
    endtask

    task automatic step();
        exp_t e, o;
        bit [1:0] m4, m2;
        bit rst_s, mce_s;
        e.lw = (ResultSrcE == 2'b01) && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
        m4 = mcexp(left4, rel4);
        m2 = mcexp(left2, rel2);
        e.mc4 = m4[1]; e.mc2 = m2[1];
        e.fa = fwd(Rs1E); e.fb = fwd(Rs2E);
        e.ctl4 = ctl(m4[1], m4[0], e.lw, PCSrcE);
        e.ctl2 = ctl(m2[1], m2[0], e.lw, PCSrcE);
        e.c4 = m_c4; e.c2 = m_c2; e.cv = m_cv;
        q.push_back(e);
        rst_s = reset; mce_s = MultiCycleE;
        @(negedge clk);
        o = q.pop_front();
        chk("fwdA4", 32'(fa4), 32'(o.fa));
        chk("fwdB4", 32'(fb4), 32'(o.fb));
        chk("fwdA2", 32'(fa2), 32'(o.fa));
        chk("fwdB2", 32'(fb2), 32'(o.fb));
        chk("ctl4", 32'({sf4, sd4, fd4, se4, fe4, fm4, mb4}), 32'(o.ctl4));
        chk("ctl2", 32'({sf2, sd2, fd2, se2, fe2, fm2, mb2}), 32'(o.ctl2));
        if (o.cv) begin
            chk("cnt4", cnt4, o.c4);
            chk("cnt2", 32'(cnt2), 32'(o.c2));
        end
        @(posedge clk);
        if (rst_s) begin m_c4 = '0; m_c2 = '0; m_cv = 1; end
        else begin
            if ((o.lw | o.mc4) && m_c4 != '1) m_c4++;
            if ((o.lw | o.mc2) && m_c2 != '1) m_c2++;
        end
        adv(4, mce_s, rst_s, left4, rel4);
        adv(2, mce_s, rst_s, left2, rel2);
        #1;
    endtask

    task automatic idle_in();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MultiCycleE = 0;
    endtask

    initial begin
        reset = 1; idle_in();
        step(); step();
        reset = 0;

        // forwarding priority
        Rs1E = 5; Rs2E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; step();
        RdM = 0; step();
        RdW = 0; step();
        idle_in();

        // load-use, then same with RdE=0, then branch
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; step();
        ResultSrcE = 2'b00; step();
        ResultSrcE = 2'b01; RdE = 0; step();
        idle_in(); PCSrcE = 1; step();
        idle_in(); step();

        // multi-cycle op held high (MC_LAT=4: 3 stalls; MC_LAT=2: back-to-back)
        MultiCycleE = 1; repeat (4) step();
        MultiCycleE = 0; repeat (2) step();

        // reset in the second BUSY cycle, release with MultiCycleE=0
        MultiCycleE = 1; step();
        MultiCycleE = 0; step();
        reset = 1; step();
        reset = 0; step(); step();

        // sustained load-use stalls drive the 3-bit counter to saturation
        ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; repeat (10) step();
        idle_in(); step();

        // random mix
        for (int i = 0; i < 150; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            ResultSrcE = 2'($urandom);
            PCSrcE = ($urandom_range(0, 3) == 0);
            MultiCycleE = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 30) == 0);
            step();
        end
        reset = 0; idle_in(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
